// File: rtl/nonce_sweep_scheduler_if.sv
// Scheduler bundle: header offer, SHA issue, in-order results, winning-nonce output.
// Stats ports appear only when NONCE_SCHED_STATS_EN is defined.
interface nonce_sweep_scheduler_if #(
  parameter int NONCE_W = 32,
  parameter int STATE_W = 352
);
  logic               blk_valid;
  logic               blk_ready;
  logic [STATE_W-1:0] blk_state;
  logic [NONCE_W-1:0] blk_nonce_first;
  logic [NONCE_W-1:0] blk_nonce_last;
  logic               stall;
  logic               issue_valid;
  logic               issue_new;
  logic [STATE_W-1:0] issue_state;
  logic [NONCE_W-1:0] issue_nonce;
  logic               issue_tag;
  logic               res_valid;
  logic               res_success;
  logic               res_tag;
  logic               out_valid;
  logic               out_ready;
  logic [NONCE_W-1:0] out_nonce;
  logic               overflow;
  logic               busy;
  logic               done;
`ifdef NONCE_SCHED_STATS_EN
  logic [47:0]        hashes_done;
  logic [15:0]        wins;

  modport master (
    output blk_valid, blk_state, blk_nonce_first, blk_nonce_last,
    output stall, res_valid, res_success, res_tag, out_ready,
    input  blk_ready, issue_valid, issue_new, issue_state,
    input  issue_nonce, issue_tag, out_valid, out_nonce,
    input  overflow, busy, done, hashes_done, wins
  );

  modport slave (
    input  blk_valid, blk_state, blk_nonce_first, blk_nonce_last,
    input  stall, res_valid, res_success, res_tag, out_ready,
    output blk_ready, issue_valid, issue_new, issue_state,
    output issue_nonce, issue_tag, out_valid, out_nonce,
    output overflow, busy, done, hashes_done, wins
  );
`else
  modport master (
    output blk_valid, blk_state, blk_nonce_first, blk_nonce_last,
    output stall, res_valid, res_success, res_tag, out_ready,
    input  blk_ready, issue_valid, issue_new, issue_state,
    input  issue_nonce, issue_tag, out_valid, out_nonce,
    input  overflow, busy, done
  );

  modport slave (
    input  blk_valid, blk_state, blk_nonce_first, blk_nonce_last,
    input  stall, res_valid, res_success, res_tag, out_ready,
    output blk_ready, issue_valid, issue_new, issue_state,
    output issue_nonce, issue_tag, out_valid, out_nonce,
    output overflow, busy, done
  );
`endif
endinterface

// File: rtl/nonce_sweep_scheduler.sv
// Sweeps a nonce range into the SHA pipe, matches results, queues winners.
// NONCE_SCHED_STATS_EN adds saturating hashes_done / wins counters.
module nonce_sweep_scheduler #(
  parameter int NONCE_W    = 32,
  parameter int STATE_W    = 352,
  parameter int FIFO_DEPTH = 4,
  parameter int INFLIGHT_W = 8
) (
  input logic clk,
  input logic rst,
  nonce_sweep_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  tag_q, tag_d;
  logic                  new_q, new_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [STATE_W-1:0]    st_q, st_d;
  logic [NONCE_W-1:0]    nonce_q, nonce_d;
  logic [NONCE_W-1:0]    last_q, last_d;
  logic [NONCE_W-1:0]    rnonce_q, rnonce_d;
  logic [INFLIGHT_W-1:0] infl_q, infl_d;
  logic [AW:0]           wp_q, wp_d;
  logic [AW:0]           rp_q, rp_d;
  logic [NONCE_W-1:0]    mem_q [FIFO_DEPTH];

  logic accept, issue, match, dec;
  logic push, pop, empty, full, wr;

  // results carrying the old epoch tag, or arriving on an accept, are stale
  assign accept = bus.blk_valid;
  assign issue  = (state_q == SWEEP) && !bus.stall;
  assign match  = bus.res_valid && (bus.res_tag == tag_q) && !accept;
  assign dec    = match && (infl_q != '0);
  assign push   = match && bus.res_success;
  assign empty  = (wp_q == rp_q);
  assign full   = (wp_q[AW] != rp_q[AW]) &&
                  (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop    = !empty && bus.out_ready;
  assign wr     = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    new_d    = new_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    st_d     = st_q;
    nonce_d  = nonce_q;
    last_d   = last_q;
    rnonce_d = rnonce_q;
    infl_d   = infl_q;
    wp_d     = wp_q;
    rp_d     = rp_q;

    if (issue && !dec)
      infl_d = infl_q + INFLIGHT_W'(1);
    else if (!issue && dec)
      infl_d = infl_q - INFLIGHT_W'(1);

    if (issue) begin
      nonce_d = nonce_q + NONCE_W'(1);
      new_d   = 1'b0;
    end
    if (match)
      rnonce_d = rnonce_q + NONCE_W'(1);
    if (wr)
      wp_d = wp_q + (AW+1)'(1);
    if (pop)
      rp_d = rp_q + (AW+1)'(1);
    if (push && full && !pop)
      ovf_d = 1'b1;

    unique case (state_q)
      IDLE: ;
      SWEEP: if (issue && (nonce_q == last_q)) state_d = DRAIN;
      DRAIN: if (infl_d == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // an accept overrides everything, preempting any sweep in progress
    if (accept) begin
      state_d  = SWEEP;
      tag_d    = ~tag_q;
      new_d    = 1'b1;
      ovf_d    = 1'b0;
      done_d   = 1'b0;
      st_d     = bus.blk_state;
      nonce_d  = bus.blk_nonce_first;
      rnonce_d = bus.blk_nonce_first;
      last_d   = bus.blk_nonce_last;
      infl_d   = '0;
      wp_d     = '0;
      rp_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tag_q    <= 1'b0;
      new_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      st_q     <= '0;
      nonce_q  <= '0;
      last_q   <= '0;
      rnonce_q <= '0;
      infl_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      new_q    <= new_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      st_q     <= st_d;
      nonce_q  <= nonce_d;
      last_q   <= last_d;
      rnonce_q <= rnonce_d;
      infl_q   <= infl_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      if (wr)
        mem_q[wp_q[AW-1:0]] <= rnonce_q;
    end
  end

  assign bus.blk_ready   = 1'b1;
  assign bus.issue_valid = issue;
  assign bus.issue_new   = issue && new_q;
  assign bus.issue_state = st_q;
  assign bus.issue_nonce = nonce_q;
  assign bus.issue_tag   = tag_q;
  assign bus.out_valid   = !empty;
  assign bus.out_nonce   = mem_q[rp_q[AW-1:0]];
  assign bus.overflow    = ovf_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

`ifdef NONCE_SCHED_STATS_EN
  logic [47:0] hashes_q;
  logic [15:0] wins_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hashes_q <= '0;
      wins_q   <= '0;
    end else begin
      if (match && (hashes_q != '1))
        hashes_q <= hashes_q + 48'd1;
      if (wr && (wins_q != '1))
        wins_q <= wins_q + 16'd1;
    end
  end

  assign bus.hashes_done = hashes_q;
  assign bus.wins        = wins_q;
`endif
endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Scoreboard bench: expected issues/winners queued at stimulus time,
// popped and compared as the scheduler issues and outputs them.
module tb_nonce_sweep_scheduler;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nonce_sweep_scheduler_if #(.NONCE_W(32), .STATE_W(352)) bif ();

  nonce_sweep_scheduler #(
    .NONCE_W(32), .STATE_W(352),
    .FIFO_DEPTH(DEPTH), .INFLIGHT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct { logic [31:0] n; logic nw; } iss_t;
  typedef struct { int due; logic [31:0] n; logic tag; } pe_t;

  iss_t        exp_iss[$];
  pe_t         pipe[$];
  logic [31:0] exp_out[$];

  int n_vec = 0, n_err = 0, cyc = 0, lat = 64;
  int n_iss = 0, n_pop = 0, acc_cyc = 0, new_cyc = 0;
  int last_iss_cyc = 0, last_res_cyc = 0, done_cyc = 0;
  int win_mode = 0, stall_mode = 0;
  logic done_hit = 1'b0, tb_tag = 1'b0, m_ovf = 1'b0;
  logic [31:0] blk_first = '0, blk_last = '0;
  logic [31:0] st_word = '0, cur_st = '0;
  logic [31:0] res_n = '0, win_val = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic win(input logic [31:0] n);
    return (win_mode == 1) || (win_mode == 2 && n == win_val);
  endfunction

  task automatic monitor();
    iss_t e;
    logic rp;
    logic [31:0] nn;
    if (bif.issue_valid) begin
      if (exp_iss.size() == 0) begin
        chk("iss_extra", bif.issue_valid, 0);
      end else begin
        e = exp_iss.pop_front();
        chk("iss_nonce", bif.issue_nonce, e.n);
        chk("iss_new", bif.issue_new, e.nw);
        chk("iss_tag", bif.issue_tag, tb_tag);
        chk("iss_state", bif.issue_state[31:0], cur_st);
      end
      if (bif.issue_new) new_cyc = cyc;
      pipe.push_back('{due: cyc + lat, n: bif.issue_nonce,
                       tag: bif.issue_tag});
      last_iss_cyc = cyc;
      n_iss++;
    end
    rp = 1'b0;
    if (bif.res_valid && bif.res_tag == tb_tag && !bif.blk_valid) begin
      last_res_cyc = cyc;
      rp = bif.res_success;
    end
    chk("out_valid", bif.out_valid, exp_out.size() != 0);
    if (bif.out_valid && bif.out_ready && exp_out.size() != 0) begin
      chk("out_nonce", bif.out_nonce, exp_out.pop_front());
      n_pop++;
    end
    if (rp) begin
      if (exp_out.size() < DEPTH) exp_out.push_back(res_n);
      else m_ovf = 1'b1;
    end
    if (bif.done) begin
      done_hit = 1'b1;
      done_cyc = cyc;
    end
    if (bif.blk_valid) begin
      exp_out.delete();
      exp_iss.delete();
      m_ovf  = 1'b0;
      tb_tag = ~tb_tag;
      cur_st = st_word;
      n_iss  = 0;
      n_pop  = 0;
      new_cyc = -1;
      nn = blk_first;
      exp_iss.push_back('{n: nn, nw: 1'b1});
      while (nn != blk_last) begin
        nn++;
        exp_iss.push_back('{n: nn, nw: 1'b0});
      end
    end
  endtask

  task automatic drive();
    pe_t p;
    bif.blk_valid   = 1'b0;
    bif.res_valid   = 1'b0;
    bif.res_success = 1'b0;
    bif.res_tag     = 1'b0;
    if (stall_mode == 1) bif.stall = ~bif.stall;
    if (pipe.size() != 0 && pipe[0].due == cyc) begin
      p = pipe.pop_front();
      bif.res_valid   = 1'b1;
      bif.res_tag     = p.tag;
      bif.res_success = win(p.n);
      res_n = p.n;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) monitor();
    @(posedge clk);
    cyc++;
    #1 drive();
  endtask

  task automatic start(input logic [31:0] f, input logic [31:0] l,
                       input logic [31:0] s);
    blk_first = f;
    blk_last  = l;
    st_word   = s;
    bif.blk_nonce_first = f;
    bif.blk_nonce_last  = l;
    bif.blk_state = {11{s}};
    bif.blk_valid = 1'b1;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    done_hit = 1'b0;
    for (int i = 0; i < budget && !done_hit; i++) step();
    chk("done_seen", done_hit, 1);
  endtask

  initial begin
    bif.blk_valid = 1'b0;
    bif.blk_state = '0;
    bif.blk_nonce_first = '0;
    bif.blk_nonce_last  = '0;
    bif.stall = 1'b0;
    bif.res_valid = 1'b0;
    bif.res_success = 1'b0;
    bif.res_tag = 1'b0;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bif.blk_ready, 1);
    chk("rst_busy", bif.busy, 0);
    chk("rst_issue", bif.issue_valid, 0);
    chk("rst_oval", bif.out_valid, 0);
    chk("rst_ovf", bif.overflow, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_nonce", bif.issue_nonce, 0);
    chk("rst_tag", bif.issue_tag, 0);
    rst = 1'b0;
    step();

    // basic sweep through a 64-deep pipe
    lat = 64; win_mode = 0;
    start(32'h10, 32'h13, 32'hA5A50001);
    step();
    chk("t1_busy_on", bif.busy, 1);
    wait_done(200);
    chk("t1_niss", n_iss, 4);
    chk("t1_new_at", new_cyc - acc_cyc, 1);
    chk("t1_done_lat", done_cyc - last_res_cyc, 1);
    chk("t1_done_pulse", bif.done, 0);
    chk("t1_busy_off", bif.busy, 0);
    chk("t1_iss_left", exp_iss.size(), 0);

    // single-nonce range at the top of the space
    win_mode = 2; win_val = 32'hFFFFFFFF; bif.out_ready = 1'b1;
    start(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5A5A0002);
    wait_done(200);
    step(); step();
    chk("t2_niss", n_iss, 1);
    chk("t2_npop", n_pop, 1);

    // wrapping range with alternate-cycle stall
    lat = 8; win_mode = 0; bif.out_ready = 1'b0;
    stall_mode = 1; bif.stall = 1'b0;
    start(32'hFFFFFFFE, 32'h1, 32'h33330003);
    wait_done(100);
    stall_mode = 0; bif.stall = 1'b0;
    chk("t3_niss", n_iss, 4);
    chk("t3_span", last_iss_cyc - acc_cyc, 8);

    // six winners into a four-entry FIFO
    win_mode = 1;
    start(32'h100, 32'h105, 32'h44440004);
    wait_done(100);
    chk("t4_ovf", bif.overflow, 1);
    chk("t4_oval", bif.out_valid, 1);
    bif.out_ready = 1'b1;
    repeat (4) step();
    bif.out_ready = 1'b0;
    chk("t4_npop", n_pop, 4);
    chk("t4_empty", bif.out_valid, 0);
    chk("t4_ovf_kept", bif.overflow, 1);

    // preempt a sweep with 20 hashes in flight
    lat = 20;
    start(32'h1000, 32'h10FF, 32'h55550005);
    for (int i = 0; i < 100 && n_iss < 30; i++) step();
    chk("t5_pre_niss", n_iss, 30);
    chk("t5_pre_ovf", bif.overflow, m_ovf);
    chk("t5_pre_oval", bif.out_valid, 1);
    start(32'h2000, 32'h2003, 32'h66660006);
    step();
    chk("t5_tag", bif.issue_tag, tb_tag);
    chk("t5_ovf_clr", bif.overflow, 0);
    chk("t5_flush", bif.out_valid, 0);
    bif.out_ready = 1'b1;
    wait_done(200);
    step();
    chk("t5_new_at", new_cyc - acc_cyc, 1);
    chk("t5_npop", n_pop, 4);
    chk("t5_niss", n_iss, 4);

    // asynchronous reset while draining with FIFO occupied
    lat = 4; bif.out_ready = 1'b0;
    start(32'h3000, 32'h3003, 32'h77770007);
    for (int i = 0; i < 50 && !bif.out_valid; i++) step();
    chk("t6_pre_busy", bif.busy, 1);
    chk("t6_pre_oval", bif.out_valid, 1);
    rst = 1'b1;
    pipe.delete();
    exp_out.delete();
    exp_iss.delete();
    tb_tag = 1'b0;
    m_ovf = 1'b0;
    bif.res_valid = 1'b0;
    #1;
    chk("t6_busy", bif.busy, 0);
    chk("t6_issue", bif.issue_valid, 0);
    chk("t6_oval", bif.out_valid, 0);
    chk("t6_ready", bif.blk_ready, 1);
    chk("t6_ovf", bif.overflow, 0);
    chk("t6_tag", bif.issue_tag, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("t6_idle", bif.busy, 0);

    // normal operation after reset
    win_mode = 2; win_val = 32'h41; bif.out_ready = 1'b1;
    start(32'h40, 32'h41, 32'h88880008);
    wait_done(50);
    step();
    chk("t7_npop", n_pop, 1);
    chk("t7_tag", bif.issue_tag, tb_tag);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
